cdc_rr_handshake_tx: RTL

Source-domain controller that shares one four-phase req/ack clock-domain-crossing channel among NUM_REQ local requesters using round-robin arbitration. It latches the winner's data and ID and drives a level request to the destination domain. It brings the returned asynchronous acknowledge back through an internal sync_2ff instance, with WIDTH=1 and the same clk/rst. Sits between local producers and the destination-side handshake receiver; the bundled data is held stable for the whole handshake.

---
 rtl/cdc_rr_handshake_tx.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/cdc_rr_handshake_tx.sv
// cdc_rr_handshake_tx
// Source side of a four-phase req/ack crossing shared by NUM_REQ local
// requesters. A round-robin arbiter picks one requester while idle; its
// payload and index are registered and held as a bundle for the whole
// handshake. The asynchronous acknowledge is brought in through sync_2ff.

// Two-flop synchronizer; the first stage is the metastability catcher.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// state  | meaning
// IDLE   | no handshake open; grant when a requester is valid and ack_s is low
// REQ_HI | xfer_req driven high; waiting for the synchronized ack to rise
// REQ_LO | xfer_req released; waiting for the synchronized ack to fall
module cdc_rr_handshake_tx #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            src_valid,
    input  logic [NUM_REQ*DATA_W-1:0]     src_data,
    output logic [NUM_REQ-1:0]            src_ready,
    output logic                          xfer_req,
    output logic [DATA_W-1:0]             xfer_data,
    output logic [$clog2(NUM_REQ)-1:0]    xfer_id,
    input  logic                          xfer_ack_async,
    output logic                          busy,
    output logic                          done
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic              ack_s;
    logic              win_found;
    logic [ID_W-1:0]   win_idx;
    logic [DATA_W-1:0] win_data;
    logic              grant;

    sync_2ff #(
        .WIDTH (1)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (xfer_ack_async),
        .q   (ack_s)
    );

    // Round-robin search: first valid index starting at rr_ptr, wrapping.
    // The sum is one bit wider so the wrap compare works for any NUM_REQ.
    always_comb begin : win_search
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        sum       = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            cand = sum[ID_W-1:0];
            if (!win_found && src_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Select the winner's payload lane.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == ID_W'(i)) begin
                win_data = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // A stale high ack (e.g. left over from before a reset) blocks new grants.
    assign grant = (state == IDLE) && win_found && !ack_s;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic following the four-phase handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = REQ_HI;
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    state_nxt = REQ_LO;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Combinational outputs: one-hot accept strobe and busy flag.
    always_comb begin
        src_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            src_ready[i] = grant && (win_idx == ID_W'(i));
        end
        busy = (state != IDLE);
    end

    // Registered bundle, request level, pointer and completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_req  <= 1'b0;
            xfer_data <= '0;
            xfer_id   <= '0;
            rr_ptr    <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == REQ_LO) && !ack_s;
            if (grant) begin
                xfer_req  <= 1'b1;
                xfer_data <= win_data;
                xfer_id   <= win_idx;
                rr_ptr    <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
            end else if ((state == REQ_HI) && ack_s) begin
                xfer_req  <= 1'b0;
            end
        end
    end

endmodule
